// File: rtl/i2c_temp_pkg.sv
// Shared definitions for the I2C temperature sensor target and the I2C master
// that talks to it: responder FSM states, register pointer map, default address.
package i2c_temp_pkg;

    localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h4B;

    localparam logic [7:0] PTR_TEMP_MSB = 8'h00;
    localparam logic [7:0] PTR_TEMP_LSB = 8'h01;
    localparam logic [7:0] PTR_DEV_ID   = 8'h0B;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_PTR      = 3'd3;
    localparam logic [2:0] ST_PTR_ACK  = 3'd4;
    localparam logic [2:0] ST_TX_BYTE  = 3'd5;
    localparam logic [2:0] ST_TX_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the raw SCL/SDA lines into the clk_100MHz domain and derives SCL
// edges plus START/STOP conditions from the synchronized values only.
module i2c_bus_sync (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_level,
    output logic start_det,
    output logic stop_det
);

    // _p0 is the metastability flop, _p1 the synchronized level, _p2 the history
    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    // Two-flop synchronizer plus history flop; reset to an idle (high) bus
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign sda_level =  sda_p1;
    // SDA may only change while SCL is low, so an SDA edge with SCL held high is a bus condition
    assign start_det =  scl_p1 & scl_p2 &  sda_p2 & ~sda_p1;
    assign stop_det  =  scl_p1 & scl_p2 & ~sda_p2 &  sda_p1;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target exposing a snapshotted 16-bit temperature word and an ID byte
// through an auto-incrementing 8-bit register pointer.
module i2c_temp_responder
    import i2c_temp_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = I2C_ADDR_DEFAULT,
    parameter logic [7:0] ID_VALUE = 8'hCB
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_data,
    output logic        busy,
    output logic        rd_done
);

    logic       scl_rise, scl_fall, sda_level, start_det, stop_det;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] tx_shift;
    logic [15:0] snapshot;
    logic [7:0] ptr;
    logic       rw_bit;
    logic       ptr_seen;
    logic [7:0] rd_byte;

    i2c_bus_sync u_sync (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .sda_level  (sda_level),
        .start_det  (start_det),
        .stop_det   (stop_det)
    );

    function automatic logic [7:0] read_mux(input logic [7:0] p, input logic [15:0] snap);
        case (p)
            PTR_TEMP_MSB: read_mux = snap[15:8];
            PTR_TEMP_LSB: read_mux = snap[7:0];
            PTR_DEV_ID:   read_mux = ID_VALUE;
            default:      read_mux = 8'h00;
        endcase
    endfunction

    assign rd_byte = read_mux(ptr, snapshot);

    // Protocol FSM: bus conditions override edges, bits sampled on SCL rise, SDA driven on SCL fall
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            tx_shift  <= 8'h00;
            snapshot  <= 16'h0000;
            ptr       <= 8'h00;
            rw_bit    <= 1'b0;
            ptr_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_level};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift_reg[7:1] == I2C_ADDR) begin
                                state    <= ST_ADDR_ACK;
                                sda_oe   <= 1'b1;
                                busy     <= 1'b1;
                                rw_bit   <= shift_reg[0];
                                ptr_seen <= 1'b0;
                                // Freeze the word so MSB and LSB of one read stay coherent
                                if (shift_reg[0]) snapshot <= temp_data;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_bit) begin
                                // The ACK release and the first data bit share this falling edge
                                state    <= ST_TX_BYTE;
                                sda_oe   <= ~rd_byte[7];
                                tx_shift <= {rd_byte[6:0], 1'b0};
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_level};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state   <= ST_PTR_ACK;
                            sda_oe  <= 1'b1;
                            bit_cnt <= 4'd0;
                            // Only the first write byte is the pointer; later ones are ACKed and dropped
                            if (!ptr_seen) begin
                                ptr      <= shift_reg;
                                ptr_seen <= 1'b1;
                            end
                        end
                    end
                    ST_PTR_ACK: begin
                        if (scl_fall) begin
                            state  <= ST_PTR;
                            sda_oe <= 1'b0;
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe   <= ~rd_byte[7];
                                tx_shift <= {rd_byte[6:0], 1'b0};
                            end else if (bit_cnt == 4'd8) begin
                                state  <= ST_TX_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                sda_oe   <= ~tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= 4'd0;
                            if (sda_level) begin
                                rd_done <= 1'b1;
                                state   <= ST_IGNORE;
                            end else begin
                                state <= ST_TX_BYTE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bench for i2c_temp_responder: a bit-banged I2C master drives directed
// transfers while a transaction-level register model predicts every bus bit.
module tb_i2c_temp_responder;
  import i2c_temp_pkg::*;

  localparam int Q = 10;
  localparam time WATCHDOG_T = 5ms;

  logic        clk_100MHz = 1'b0;
  logic        rst_n;
  logic        scl_m;
  logic        sda_m;
  logic [15:0] temp_data;
  logic        sda_oe;
  logic        busy;
  logic        rd_done;
  wire         sda_bus = sda_m & ~sda_oe;

  always #5 clk_100MHz = ~clk_100MHz;

  i2c_temp_responder dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .temp_data  (temp_data),
    .busy       (busy),
    .rd_done    (rd_done)
  );

  // Reference model: register map, pointer, snapshot, busy flag, NACK count
  logic [7:0]  m_ptr;
  logic [15:0] m_snap;
  logic        m_busy;
  int          m_nacks;

  function automatic logic [7:0] m_reg(input logic [7:0] p, input logic [15:0] s);
    if (p == 8'h00)      return s[15:8];
    else if (p == 8'h01) return s[7:0];
    else if (p == 8'h0B) return 8'hCB;
    else                 return 8'h00;
  endfunction

  // Single compare process
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_rd_done = 0;
  logic        req_en = 1'b0;
  logic        req_dut = 1'b0;
  logic [15:0] req_act = 16'h0;
  logic [15:0] req_exp = 16'h0;
  string       req_name = "";
  logic        stim_done = 1'b0;

  always @(negedge clk_100MHz) begin
    logic [15:0] act;
    if (rd_done === 1'b1) n_rd_done++;
    if (req_en) begin
      act = req_dut ? {13'd0, rd_done, busy, sda_oe} : req_act;
      n_vec++;
      if (act !== req_exp) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", req_name, act, req_exp);
      end
    end
  end

  initial begin
    fork
      wait (stim_done === 1'b1);
      #(WATCHDOG_T);
    join_any
    disable fork;
    if (stim_done !== 1'b1) begin
      n_bad++;
      $display("FAIL watchdog: stimulus did not finish within %0t", WATCHDOG_T);
      $finish;
    end
  end

  task automatic post(input string name, input logic dut_sample,
                      input logic [15:0] act, input logic [15:0] exp);
    @(posedge clk_100MHz);
    req_name = name;
    req_dut  = dut_sample;
    req_act  = act;
    req_exp  = exp;
    req_en   = 1'b1;
    @(posedge clk_100MHz);
    req_en   = 1'b0;
  endtask

  // Compares {rd_done, busy, sda_oe} against the model
  task automatic probe(input string name, input logic exp_oe);
    post(name, 1'b1, 16'h0, {13'd0, 1'b0, m_busy, exp_oe});
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    post(name, 1'b0, act, exp);
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk_100MHz);
  endtask

  task automatic clock_bit(input logic mbit, input logic chk, input logic exp_oe,
                           input string name, output logic got);
    sda_m = mbit;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    got = sda_bus;
    if (chk) probe(name, exp_oe);
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
    m_busy = 1'b0;
    probe("after_stop", 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic ack_exp,
                            input logic is_addr, input string name);
    logic got;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b1, 1'b0, name, got);
    if (is_addr && ack_exp) m_busy = 1'b1;
    clock_bit(1'b1, 1'b1, ack_exp, {name, "_ack"}, got);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack,
                           input string name, output logic [7:0] got_b);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b1, ~exp[i], name, bt);
      got_b[i] = bt;
    end
    clock_bit(nack, 1'b1, 1'b0, {name, "_mack"}, bt);
    check_val({name, "_byte"}, {8'd0, got_b}, {8'd0, exp});
  endtask

  task automatic set_ptr(input logic [7:0] p);
    i2c_start();
    write_byte(8'h96, 1'b1, 1'b1, "addr_w");
    write_byte(p, 1'b1, 1'b0, "ptr_byte");
    m_ptr = p;
  endtask

  task automatic begin_read();
    i2c_start();
    m_snap = temp_data;
    write_byte(8'h97, 1'b1, 1'b1, "addr_r");
  endtask

  task automatic read_next(input logic nack, input string name, output logic [7:0] got);
    read_byte(m_reg(m_ptr, m_snap), nack, name, got);
    m_ptr = m_ptr + 8'd1;
    if (nack) m_nacks++;
  endtask

  initial begin
    logic [7:0] b;
    logic       dummy;
    logic       oe_snap;
    int         rd0;

    rst_n     = 1'b0;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    temp_data = 16'h0C80;
    m_ptr     = 8'h00;
    m_snap    = 16'h0000;
    m_busy    = 1'b0;
    m_nacks   = 0;
    repeat (5) @(posedge clk_100MHz);
    #1;
    if (sda_oe !== 1'b0 || busy !== 1'b0 || rd_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: sda_oe=%b busy=%b rd_done=%b, required 0 0 0",
               sda_oe, busy, rd_done);
    end
    probe("reset_state", 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk_100MHz);
    probe("idle_state", 1'b0);

    // Pointer 0, repeated START, two-byte read
    set_ptr(8'h00);
    begin_read();
    rd0 = n_rd_done;
    read_next(1'b0, "t1_msb", b);
    check_val("t1_msb_lit", {8'd0, b}, 16'h000C);
    read_next(1'b1, "t1_lsb", b);
    check_val("t1_lsb_lit", {8'd0, b}, 16'h0080);
    i2c_stop();
    check_val("t1_rd_done_once", 16'(n_rd_done - rd0), 16'd1);

    // ID register, then continued read from the advanced pointer
    set_ptr(8'h0B);
    begin_read();
    read_next(1'b1, "t2_id", b);
    check_val("t2_id_lit", {8'd0, b}, 16'h00CB);
    i2c_stop();
    check_val("t2_model_ptr", {8'd0, m_ptr}, 16'h000C);
    begin_read();
    read_next(1'b1, "t2_next", b);
    check_val("t2_next_lit", {8'd0, b}, 16'h0000);
    i2c_stop();

    // Extra write byte is ACKed but leaves the pointer alone
    set_ptr(8'h01);
    write_byte(8'h55, 1'b1, 1'b0, "t3_extra");
    i2c_stop();
    begin_read();
    read_next(1'b1, "t3_lsb", b);
    check_val("t3_lsb_lit", {8'd0, b}, 16'h0080);
    i2c_stop();

    // Foreign address: no ACK, no drive, not busy
    i2c_start();
    write_byte(8'h90, 1'b0, 1'b1, "t4_addr");
    write_byte(8'h00, 1'b0, 1'b0, "t4_data");
    i2c_stop();

    // temp_data changes mid-read; snapshot keeps the LSB coherent
    set_ptr(8'h00);
    begin_read();
    read_next(1'b0, "t5_msb", b);
    check_val("t5_msb_lit", {8'd0, b}, 16'h000C);
    temp_data = 16'h1F00;
    read_next(1'b1, "t5_lsb", b);
    check_val("t5_lsb_lit", {8'd0, b}, 16'h0080);
    i2c_stop();

    // Pointer wrap from 0xFF
    temp_data = 16'hA55A;
    set_ptr(8'hFF);
    begin_read();
    read_next(1'b0, "t6_ff", b);
    check_val("t6_ff_lit", {8'd0, b}, 16'h0000);
    read_next(1'b1, "t6_wrap", b);
    check_val("t6_wrap_lit", {8'd0, b}, 16'h00A5);
    i2c_stop();
    check_val("t6_model_ptr", {8'd0, m_ptr}, 16'h0001);
    begin_read();
    read_next(1'b1, "t6_after", b);
    check_val("t6_after_lit", {8'd0, b}, 16'h005A);
    i2c_stop();

    // Asynchronous reset while the target pulls SDA low for a 0 bit
    temp_data = 16'h0C80;
    set_ptr(8'h00);
    begin_read();
    probe("t7_driving_zero", 1'b1);
    @(posedge clk_100MHz);
    #2;
    rst_n = 1'b0;
    #1;
    oe_snap = sda_oe;
    check_val("t7_async_release", {15'd0, oe_snap}, 16'h0000);
    m_ptr  = 8'h00;
    m_busy = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) clock_bit(i[0], 1'b1, 1'b0, "t7_no_resp", dummy);
    i2c_stop();
    begin_read();
    read_next(1'b0, "t7_msb", b);
    check_val("t7_msb_lit", {8'd0, b}, 16'h000C);
    read_next(1'b1, "t7_lsb", b);
    check_val("t7_lsb_lit", {8'd0, b}, 16'h0080);
    i2c_stop();

    check_val("rd_done_total", 16'(n_rd_done), 16'(m_nacks));

    stim_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
